ir_queue: RTL
=============

# ir_queue

Parametrised instruction-register queue for the bus-based MIPS core, the successor to the single-entry instruction register. It captures instruction words returned on the memory read bus into a DEPTH-entry FIFO, so fetch can run ahead of a stalled execute stage. It presents the head instruction, fully field-sliced, to the control path, and supports flush on taken branches and jumps.

## Interface
- DEPTH, 4, number of stored instruction entries; power of two, ≥2
- WORD_W, 32, instruction width; only 32 is legal for MIPS field slicing
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- fill_valid  in  1  read_data holds a fetched instruction this cycle
- read_data  in  WORD_W  fetched instruction word from memory bus
- fill_ready  out  1  queue can accept a word (count < DEPTH)
- pop  in  1  control path consumes head instruction
- flush  in  1  discard all queued instructions (branch/jump redirect)
- head_valid  out  1  instruction_word is a real fetched instruction
- instruction_word  out  WORD_W  head instruction; 32'h0000_0000 (NOP) when !head_valid
- instruction_opcode  out  6  instruction_word[31:26]
- rs / rt / rd  out  5 each  [25:21] / [20:16] / [15:11]
- shamt  out  5  [10:6]
- alu_immediate  out  16  [15:0]
- func_code  out  6  [5:0]
- special_branch_codes  out  5  [20:16] (REGIMM selector)
- count  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH

## Operation
- Circular buffer; wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits, wrap modulo 2·DEPTH; full when MSBs differ and low bits match.
- push = fill_valid & fill_ready; writes read_data at wr_ptr, wr_ptr+1.
- pop_fire = pop & head_valid; rd_ptr+1. A pop while !head_valid is ignored and causes no pointer change.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: fill_ready=0, so a word offered while full is not accepted (bus master must hold it). There is no pass-through even if pop is high.
- flush has priority over push and pop in the same cycle:
  - both pointers reset to 0 and count goes to 0;
  - read_data offered in the flush cycle is dropped, even if fill_ready=1.
- Decode fields are pure slices of instruction_word. When empty they are all zero, so downstream sees NOP.
- Storage array is not reset. Pointers and count are reset.
- Reset values: count=0, head_valid=0, fill_ready=1, instruction_word=0, all fields 0.
- Reset asserted mid-operation discards all contents immediately (asynchronous).

## Timing
- Without bypass: read_data accepted at edge N appears at the head after edge N, i.e. 1-cycle latency.
- pop at edge N: next entry is presented after edge N; back-to-back pops every cycle are allowed.
- fill_ready and head_valid are combinational from the registered pointers only, never from fill_valid/pop, except head_valid under the bypass option.
- flush takes effect at the next edge. In the flush cycle itself, outputs still show pre-flush contents.

## Configuration
- IR_QUEUE_BYPASS_EN defined:
  - when count==0 and fill_valid=1, head_valid=1 and instruction_word=read_data combinationally;
  - pop in that cycle consumes the word without writing it, so neither pointer moves;
  - this gives zero-latency behaviour matching the single-entry register.
- IR_QUEUE_BYPASS_EN undefined: head comes only from storage; strict 1-cycle fill-to-head latency.
- flush still suppresses bypass: when flush=1, head_valid=0.

## Structure
- Shared package ir_pkg:
  - field bit-position localparams;
  - MIPS_NOP = 32'h0;
  - typedef struct packed ir_fields_t {opcode, rs, rt, rd, shamt, imm, funct}.
- Sub-module ir_field_decode: combinational WORD_W → ir_fields_t slicing, reused by any later decode stage.
- Top module holds storage, pointers, bypass mux and flush logic.

## Test plan
- Reset, then push 32'h2008_0005 (addi $t0,$0,5):
  - head_valid=1 one cycle later;
  - opcode=6'h08, rs=0, rt=8, alu_immediate=16'h0005.
- Push DEPTH words with no pop:
  - count=DEPTH, fill_ready=0;
  - 5th offered word not stored;
  - pops return words in push order.
- Simultaneous push and pop with count=2 for 10 cycles:
  - count stays 2;
  - output order is preserved across pointer wrap.
- count=3, flush and fill_valid asserted together:
  - next cycle count=0, head_valid=0, instruction_word=0;
  - flushed-cycle word is absent.
- pop while empty: no change to count or pointers. Then assert rst_n=0 mid-stream with count=3: count=0 immediately.
- With IR_QUEUE_BYPASS_EN, empty queue, fill_valid with 32'h0000_0008 (jr $0) and pop in the same cycle:
  - head_valid=1 and func_code=6'h08 in that cycle;
  - count remains 0 afterward.

Source files
------------

// File: rtl/ir_queue_pkg.sv
// Shared definitions for the instruction-register queue: MIPS field bit
// positions, the NOP encoding and the decoded-field record type.
package ir_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [5:0]  funct;
  } ir_fields_t;

endpackage

// File: rtl/ir_queue_field_decode.sv
// ir_field_decode: purely combinational slicing of a MIPS instruction word
// into its named fields. Kept separate so later decode stages can reuse it.
module ir_field_decode
  import ir_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] word,
  output ir_fields_t        fields
);

  // Slice every field straight out of the word; overlapping fields are intentional.
  always_comb begin
    fields.opcode = word[OPCODE_MSB:OPCODE_LSB];
    fields.rs     = word[RS_MSB:RS_LSB];
    fields.rt     = word[RT_MSB:RT_LSB];
    fields.rd     = word[RD_MSB:RD_LSB];
    fields.shamt  = word[SHAMT_MSB:SHAMT_LSB];
    fields.imm    = word[IMM_MSB:IMM_LSB];
    fields.funct  = word[FUNCT_MSB:FUNCT_LSB];
  end

endmodule

// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry FIFO of fetched instruction words with a field-sliced
// head output and flush for branch/jump redirects.
// Optional feature: define IR_QUEUE_BYPASS_EN to let a word arriving on an
// empty queue appear at the head in the same cycle (zero-latency path).
module ir_queue
  import ir_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fill_valid,
  input  logic [WORD_W-1:0]        read_data,
  output logic                     fill_ready,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [WORD_W-1:0]        instruction_word,
  output logic [5:0]               instruction_opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [15:0]              alu_immediate,
  output logic [5:0]               func_code,
  output logic [4:0]               special_branch_codes,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              empty;
  logic              full;
  logic              bypass_sel;
  logic              bypass_pop;
  logic              do_push;
  logic              do_pop;
  logic [WORD_W-1:0] head_word;
  ir_fields_t        fields;

  // Status, handshake and head selection; flush blocks any state change and
  // also hides a bypassed word, while stored contents stay visible until the edge.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    fill_ready = !full;
    count      = wr_ptr - rd_ptr;
`ifdef IR_QUEUE_BYPASS_EN
    bypass_sel = empty && fill_valid && !flush;
`else
    bypass_sel = 1'b0;
`endif
    bypass_pop = bypass_sel && pop;
    head_valid = !empty || bypass_sel;
    do_push    = fill_valid && !full && !flush && !bypass_pop;
    do_pop     = pop && !empty && !flush;
    head_word  = bypass_sel ? read_data : mem[rd_ptr[IDX_W-1:0]];
    instruction_word = head_valid ? head_word : WORD_W'(MIPS_NOP);
  end

  // Pointer registers: reset and flush both return the queue to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage array is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= read_data;
  end

  ir_field_decode #(
    .WORD_W (WORD_W)
  ) u_decode (
    .word   (instruction_word),
    .fields (fields)
  );

  // Fan the decoded record out to the named control-path ports.
  always_comb begin
    instruction_opcode   = fields.opcode;
    rs                   = fields.rs;
    rt                   = fields.rt;
    rd                   = fields.rd;
    shamt                = fields.shamt;
    alu_immediate        = fields.imm;
    func_code            = fields.funct;
    special_branch_codes = fields.rt;
  end

endmodule
